// File: rtl/gray_pkg.sv
// Shared types and constants for the pipelined RGB-to-grayscale converter.
package gray_pkg;

  // Widest channel the lanes are built for; narrower channels are zero-extended.
  localparam int unsigned CW_MAX = 12;

  typedef struct packed {
    logic [CW_MAX-1:0] r;
    logic [CW_MAX-1:0] g;
    logic [CW_MAX-1:0] b;
  } rgb_t;

  typedef enum logic {
    GRAY_WEIGHTED = 1'b0,
    GRAY_AVERAGE  = 1'b1
  } gray_mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } gray_state_e;

  // BT.601 weights scaled by 256 (sum is exactly 256).
  localparam int unsigned COEF_R    = 77;
  localparam int unsigned COEF_G    = 150;
  localparam int unsigned COEF_B    = 29;
  // 171/512 approximates 1/3 for the plain average.
  localparam int unsigned COEF_AVG  = 171;
  localparam int unsigned SHIFT_WGT = 8;
  localparam int unsigned SHIFT_AVG = 9;
  // Half an LSB of the shifted result, used for round-half-up.
  localparam int unsigned RND_WGT   = 128;
  localparam int unsigned RND_AVG   = 256;

endpackage

// File: rtl/gray_lane.sv
// One pixel of the converter: stage 1 forms per-channel products, stage 2
// sums, optionally rounds (GRAY_ROUND_EN), shifts and saturates.
module gray_lane
  import gray_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            ld1_i,
  input  logic            ld2_i,
  input  gray_mode_e      mode_i,
  input  logic [3*CW-1:0] rgb_i,
  output logic [CW-1:0]   gray_o
);

  localparam int unsigned PW = CW + 8;
  localparam int unsigned IW = CW + 10;

  rgb_t          px;
  logic [PW-1:0] coef_r, coef_g, coef_b;
  logic [PW-1:0] prod_r_d, prod_g_d, prod_b_d;
  logic [PW-1:0] prod_r_q, prod_g_q, prod_b_q;
  gray_mode_e    mode_q;
  logic [IW-1:0] rnd, sum, y;
  logic [CW-1:0] gray_d, gray_q;

  // Unpack channels and form per-mode products
  always_comb begin
    px       = '0;
    px.r     = CW_MAX'(rgb_i[3*CW-1:2*CW]);
    px.g     = CW_MAX'(rgb_i[2*CW-1:CW]);
    px.b     = CW_MAX'(rgb_i[CW-1:0]);
    coef_r   = PW'(COEF_R);
    coef_g   = PW'(COEF_G);
    coef_b   = PW'(COEF_B);
    if (mode_i == GRAY_AVERAGE) begin
      coef_r = PW'(COEF_AVG);
      coef_g = PW'(COEF_AVG);
      coef_b = PW'(COEF_AVG);
    end
    prod_r_d = PW'(px.r) * coef_r;
    prod_g_d = PW'(px.g) * coef_g;
    prod_b_d = PW'(px.b) * coef_b;
  end

  // Sum, round, shift and clamp to the channel range
  always_comb begin
    rnd = '0;
`ifdef GRAY_ROUND_EN
    rnd = (mode_q == GRAY_AVERAGE) ? IW'(RND_AVG) : IW'(RND_WGT);
`else
    rnd = '0;
`endif
    sum    = IW'(prod_r_q) + IW'(prod_g_q) + IW'(prod_b_q) + rnd;
    y      = (mode_q == GRAY_AVERAGE) ? (sum >> SHIFT_AVG) : (sum >> SHIFT_WGT);
    gray_d = (|y[IW-1:CW]) ? '1 : y[CW-1:0];
  end

  // Pipeline registers; each stage holds while its load enable is low
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      prod_r_q <= '0;
      prod_g_q <= '0;
      prod_b_q <= '0;
      mode_q   <= GRAY_WEIGHTED;
      gray_q   <= '0;
    end else begin
      if (ld1_i) begin
        prod_r_q <= prod_r_d;
        prod_g_q <= prod_g_d;
        prod_b_q <= prod_b_d;
        mode_q   <= mode_i;
      end
      if (ld2_i) begin
        gray_q <= gray_d;
      end
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/gray_convert_pipe.sv
// NPIX-wide RGB-to-grayscale converter, 2-stage valid/ready pipeline with
// per-frame mode latch and end-of-frame pulse. Optional macro GRAY_ROUND_EN
// selects round-half-up instead of truncation (handled in gray_lane).
module gray_convert_pipe
  import gray_pkg::*;
#(
  parameter int unsigned NPIX        = 4,
  parameter int unsigned CW          = 8,
  parameter int unsigned FRAME_BEATS = 16
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NPIX*3*CW-1:0]   in_pixel_buffer,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   gray_mode,
  output logic [NPIX*CW-1:0]     gray_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   gray_done
);

  localparam int unsigned CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BEATS - 1);

  logic             rdy_q;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s1_last_q, s1_last_d;
  logic             s2_last_q, s2_last_d;
  logic             done_q, done_d;
  gray_state_e      state_q;
  gray_mode_e       mode_q;
  logic [CNT_W-1:0] cnt_q;

  logic             en2, acc, ld2, last_beat;
  gray_mode_e       beat_mode;

  // Handshake decode and stage advance
  always_comb begin
    en2        = !s2_valid_q || out_ready;
    in_ready   = rdy_q && (en2 || !s1_valid_q);
    acc        = in_valid && in_ready;
    ld2        = en2 && s1_valid_q;
    last_beat  = (cnt_q == LAST_IDX);
    beat_mode  = (state_q == ST_IDLE) ? gray_mode_e'(gray_mode) : mode_q;
    s1_valid_d = acc || (s1_valid_q && !en2);
    s1_last_d  = acc ? last_beat : s1_last_q;
    s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
    s2_last_d  = en2 ? (s1_valid_q && s1_last_q) : s2_last_q;
    done_d     = s2_valid_q && out_ready && s2_last_q;
  end

  // Pipeline valid/last tags and the end-of-frame pulse
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      done_q     <= done_d;
    end
  end

  // Frame FSM: latch mode on the first beat, count beats to the frame end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      mode_q  <= GRAY_WEIGHTED;
      cnt_q   <= '0;
    end else if (acc) begin
      cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          mode_q <= gray_mode_e'(gray_mode);
          if (!last_beat) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (last_beat) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Per-pixel arithmetic lanes sharing the pipeline control
  for (genvar i = 0; i < NPIX; i++) begin : g_lane
    gray_lane #(.CW(CW)) u_lane (
      .clk    (clk),
      .n_rst  (n_rst),
      .ld1_i  (acc),
      .ld2_i  (ld2),
      .mode_i (beat_mode),
      .rgb_i  (in_pixel_buffer[i*3*CW +: 3*CW]),
      .gray_o (gray_pixel[i*CW +: CW])
    );
  end

  assign out_valid = s2_valid_q;
  assign out_last  = s2_last_q;
  assign gray_done = done_q;

endmodule

// File: tb/tb_gray_convert_pipe.sv
// Self-checking bench for gray_convert_pipe: directed steps plus a random
// phase, checked against an arithmetic reference model and beat scoreboard.
module tb_gray_convert_pipe;

  localparam int unsigned NPIX = 4;
  localparam int unsigned CW   = 10;
  localparam int unsigned FB   = 4;
  localparam int unsigned PXW  = 3 * CW;
  localparam int unsigned MAXV = (1 << CW) - 1;
`ifdef GRAY_ROUND_EN
  localparam int unsigned RW = 128;
  localparam int unsigned RA = 256;
  localparam int unsigned AVG_EXP = 68;
`else
  localparam int unsigned RW = 0;
  localparam int unsigned RA = 0;
  localparam int unsigned AVG_EXP = 67;
`endif
  localparam int unsigned WGT_EXP = 114;

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic [NPIX*PXW-1:0]  in_pixel_buffer;
  logic                 in_valid;
  logic                 in_ready;
  logic                 gray_mode;
  logic [NPIX*CW-1:0]   gray_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 gray_done;

  gray_convert_pipe #(.NPIX(NPIX), .CW(CW), .FRAME_BEATS(FB)) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .in_pixel_buffer (in_pixel_buffer),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .gray_mode       (gray_mode),
    .gray_pixel      (gray_pixel),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .gray_done       (gray_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [NPIX*CW-1:0] exp_q[$];
  bit                 last_q[$];
  int                 beat_idx   = 0;
  bit                 frame_mode = 1'b0;
  bit                 exp_done   = 1'b0;
  bit                 was_rst    = 1'b1;
  int                 acc_count  = 0;
  int                 done_count = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference grayscale value straight from the conversion formulas.
  function automatic logic [CW-1:0] ref_y(input logic [PXW-1:0] px, input bit m);
    int unsigned r, g, b, y;
    r = px[PXW-1:2*CW];
    g = px[2*CW-1:CW];
    b = px[CW-1:0];
    if (!m) y = (77 * r + 150 * g + 29 * b + RW) / 256;
    else    y = ((r + g + b) * 171 + RA) / 512;
    if (y > MAXV) y = MAXV;
    return CW'(y);
  endfunction

  function automatic logic [NPIX*CW-1:0] ref_vec(input logic [NPIX*PXW-1:0] bus, input bit m);
    logic [NPIX*CW-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*CW +: CW] = ref_y(bus[i*PXW +: PXW], m);
    return v;
  endfunction

  function automatic logic [NPIX*PXW-1:0] rep_px(input logic [PXW-1:0] p);
    logic [NPIX*PXW-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*PXW +: PXW] = p;
    return v;
  endfunction

  function automatic logic [NPIX*CW-1:0] rep_y(input int unsigned y);
    logic [NPIX*CW-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*CW +: CW] = CW'(y);
    return v;
  endfunction

  function automatic logic [NPIX*PXW-1:0] rand_bus();
    logic [NPIX*PXW-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*PXW +: PXW] = PXW'($urandom);
    return v;
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit hs_in, hs_out, ep_last;
    #1;
    if (was_rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_gray_pixel", gray_pixel, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_gray_done", gray_done, 0);
    end else begin
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      chk("gray_done", gray_done, exp_done);
      if (exp_q.size() == 2) chk("out_valid_full", out_valid, 1);
      if (exp_q.size() == 0) chk("out_valid_empty", out_valid, 0);
      if (out_valid && exp_q.size() > 0) begin
        chk("gray_pixel", gray_pixel, exp_q[0]);
        chk("out_last", out_last, last_q[0]);
      end
    end
    hs_in   = n_rst && in_valid && in_ready;
    hs_out  = n_rst && out_valid && out_ready && (exp_q.size() > 0);
    ep_last = hs_out ? last_q[0] : 1'b0;
    @(posedge clk);
    if (!n_rst) begin
      exp_q.delete();
      last_q.delete();
      beat_idx = 0;
      exp_done = 1'b0;
      was_rst  = 1'b1;
    end else begin
      was_rst  = 1'b0;
      exp_done = hs_out && ep_last;
      if (exp_done) done_count++;
      if (hs_out) begin
        void'(exp_q.pop_front());
        void'(last_q.pop_front());
      end
      if (hs_in) begin
        if (beat_idx == 0) frame_mode = gray_mode;
        exp_q.push_back(ref_vec(in_pixel_buffer, frame_mode));
        last_q.push_back(beat_idx == int'(FB - 1));
        beat_idx = (beat_idx + 1) % FB;
        acc_count++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    int target;
    int d0;
    n_rst           = 1'b0;
    in_valid        = 1'b1;
    out_ready       = 1'b1;
    gray_mode       = 1'b0;
    in_pixel_buffer = rep_px({10'd1, 10'd193, 10'd9});

    // Reset held for two cycles with in_valid high
    @(posedge clk);
    @(negedge clk);
    was_rst = 1'b1;
    cycle();
    n_rst    = 1'b1;
    in_valid = 1'b0;
    cycle();
    chk("in_ready_after_release", in_ready, 1);

    // Weighted frame; latency of two cycles on the first beat
    in_valid  = 1'b1;
    gray_mode = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk("lat_first_cycle", out_valid, 0);
    cycle();
    chk("lat_second_cycle", out_valid, 1);
    chk("weighted_value", gray_pixel, rep_y(WGT_EXP));
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      gray_mode = i[0];
      cycle();
      if (out_valid) chk("weighted_mid_toggle", gray_pixel, rep_y(WGT_EXP));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Average frame, continuous, mode toggled after the first beat
    d0 = done_count;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      gray_mode = (i == 0) ? 1'b1 : i[0];
      cycle();
      if (out_valid) chk("average_value", gray_pixel, rep_y(AVG_EXP));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (out_valid) chk("average_value", gray_pixel, rep_y(AVG_EXP));
    end
    chk("done_per_frame", done_count - d0, 1);

    // Backpressure: out_ready low for three cycles mid-stream
    target = acc_count + 4;
    in_valid = 1'b1;
    in_pixel_buffer = rand_bus();
    gray_mode = 1'($urandom);
    cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_pixel_buffer = rand_bus();
      cycle();
    end
    #1;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_buffered", exp_q.size(), 2);
    out_ready = 1'b1;
    guard = 0;
    while (acc_count < target && guard < 20) begin
      in_pixel_buffer = rand_bus();
      cycle();
      guard++;
    end
    chk("bp_all_accepted", acc_count, target);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Mid-frame reset after three beats: no gray_done, fresh frame after
    d0 = done_count;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pixel_buffer = rand_bus();
      cycle();
    end
    in_valid = 1'b0;
    n_rst = 1'b0;
    cycle();
    n_rst = 1'b1;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("no_done_after_reset", done_count - d0, 0);

    // Saturation frame: all channels full scale, average mode
    in_pixel_buffer = rep_px({PXW{1'b1}});
    in_valid  = 1'b1;
    gray_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      gray_mode = 1'b0;
      if (out_valid) chk("saturate", gray_pixel, rep_y(MAXV));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (out_valid) chk("saturate", gray_pixel, rep_y(MAXV));
    end
    chk("done_after_reset_frame", done_count - d0, 1);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      in_valid        = ($urandom_range(9) < 7);
      out_ready       = ($urandom_range(9) < 7);
      gray_mode       = 1'($urandom);
      in_pixel_buffer = rand_bus();
      n_rst           = ($urandom_range(199) != 0);
      cycle();
    end
    n_rst     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      cycle();
      guard++;
    end
    chk("drain_empty", exp_q.size(), 0);
    cycle();
    chk("drain_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_convert_pipe.md
Name: gray_convert_pipe

Overview:
Parametrised successor to the single-beat grayscale converter in the Sobel edge-detection datapath. It converts NPIX packed RGB pixels per beat to grayscale through a 2-stage pipeline with valid/ready handshakes on both sides. Conversion is runtime-selectable: BT.601 weighted or plain average. It counts beats per frame and pulses gray_done after the last beat of a frame leaves, so the Sobel window buffer downstream can start.

Parameters:
NPIX, 4, pixels per beat
CW, 8, bits per colour channel; range 4..12
FRAME_BEATS, 16, beats per frame; minimum 1

Ports:
clk  in  1  clock; all logic on rising edge
n_rst  in  1  reset, synchronous, active-low
in_pixel_buffer  in  NPIX x 3*CW  packed pixels; per pixel R=[3CW-1:2CW], G=[2CW-1:CW], B=[CW-1:0]
in_valid  in  1  input beat valid
in_ready  out  1  converter can accept a beat
gray_mode  in  1  0 = weighted, 1 = average; sampled on the first beat of each frame
gray_pixel  out  NPIX x CW  grayscale result, same index order as input
out_valid  out  1  gray_pixel valid
out_ready  in  1  downstream accepts
out_last  out  1  asserted with out_valid on the final beat of a frame
gray_done  out  1  one-cycle pulse the cycle after the out_last beat handshakes

Behaviour:
- Reset is synchronous. While n_rst=0 at a clk edge: all valids=0, gray_pixel=0, out_last=0, gray_done=0, beat counters=0, FSM=IDLE, latched mode=0. in_ready=0 during reset and 1 from the first cycle after release.
- Handshakes:
  - Input accepted when in_valid & in_ready. Output transferred when out_valid & out_ready.
  - in_ready = !s2_valid | out_ready | !s1_valid (stall-propagating pipeline, no bubbles).
  - Data and out_last are held stable while out_valid & !out_ready.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput: 1 beat/cycle.
- Stage 1 computes per-channel products. Stage 2 sums and shifts.
  - Weighted: Y = (77R + 150G + 29B) >> 8. Coefficients sum to 256, so no overflow.
  - Average: Y = ((R+G+B) * 171) >> 9.
  - Result saturates to 2^CW-1 if it exceeds that value (reachable only in average mode for CW > 8).
  - Internal width: at least CW+10 bits.
- FSM:
  - States: IDLE and ACTIVE.
  - IDLE -> ACTIVE on the first input handshake. That beat latches gray_mode, which applies to the whole frame.
  - ACTIVE -> IDLE when input beat FRAME_BEATS-1 is accepted.
  - Changes to gray_mode in ACTIVE are ignored.
  - FRAME_BEATS=1: every beat is a first and last beat, and the FSM stays in IDLE.
- Counters:
  - The input beat counter (0..FRAME_BEATS-1, wraps) tags out_last into the pipeline.
  - An input handshake in the same cycle as an output handshake of the previous frame's last beat is legal. Both counters update independently.
  - gray_done fires exactly once per frame and is never asserted without a preceding out_last handshake.
- Boundaries:
  - in_valid held low: pipeline drains normally.
  - out_ready held low: at most 2 beats are buffered, then in_ready=0.
- Reset mid-frame discards all in-flight beats. No gray_done is issued, and the next accepted beat is beat 0 of a new frame.

Optional Feature:
Macro GRAY_ROUND_EN.
- Defined: round-half-up before the shift. Add 128 in weighted mode, 256 in average mode, then saturate.
- Undefined: truncate, as specified above.
- Latency and handshakes are identical either way.

Decomposition:
- Package gray_pkg holds:
  - typedef rgb_t (packed struct r,g,b of CW bits)
  - typedef gray_mode_e {GRAY_WEIGHTED, GRAY_AVERAGE}
  - localparams for coefficients 77/150/29, 171, shifts 8/9, and rounding constants
  - FSM state enum
- One natural sub-module: gray_lane, the per-pixel 2-stage arithmetic with a stall enable. It is instantiated NPIX times under a generate loop. Handshake, FSM and counters live in the top module.

Test Plan:
- Reset: hold n_rst=0 for 2 cycles with in_valid=1 -> out_valid=0, gray_pixel=0, gray_done=0, in_ready=0; in_ready=1 one cycle after release.
- Weighted: all 4 pixels = 24'h01C109 (R=1, G=193, B=9), mode 0, out_ready=1 -> each gray_pixel=114 two cycles later (114 with GRAY_ROUND_EN).
- Average: same pixels, mode 1 at frame start -> each gray_pixel=67 (68 with GRAY_ROUND_EN). Toggling gray_mode mid-frame leaves results unchanged.
- Backpressure: stream 4 beats, drop out_ready for 3 cycles mid-stream -> in_ready falls after 2 beats are buffered, outputs stay stable, no beat lost or duplicated, order preserved.
- Frame: FRAME_BEATS=4 with continuous stream -> out_last on output beats 3 and 7; gray_done pulses 1 cycle after each.
- Saturation and mid-frame reset: CW=10, average mode, all channels 1023 -> gray_pixel=1023. Reset after beat 2 of a frame -> no gray_done, and the next frame's out_last lands on its 4th beat.
